// File: rtl/if_fetch_pkg.sv
// Shared types and helpers for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int BYTE_W = 8;
  localparam int INST_W = 32;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_REQ   = 2'd1,
    IF_DRAIN = 2'd2
  } if_state_e;

  // Little-endian byte lane k of the word replaced by b.
  function automatic logic [INST_W-1:0] insert_byte(input logic [INST_W-1:0] word,
                                                     input logic [1:0] k,
                                                     input logic [BYTE_W-1:0] b);
    logic [INST_W-1:0] w;
    w = word;
    w[{k, 3'b000} +: BYTE_W] = b;
    return w;
  endfunction

endpackage

// File: rtl/if_fetch_icache.sv
// Direct-mapped one-word-per-line instruction cache; compiled only with IF_ICACHE_EN.
`ifdef IF_ICACHE_EN
module if_fetch_icache
  import if_fetch_pkg::*;
#(
  parameter int LINES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:2]       lookup_pc,
  output logic              hit,
  output logic [INST_W-1:0] rdata,
  input  logic              fill,
  input  logic [31:2]       fill_pc,
  input  logic [INST_W-1:0] fill_data
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 32 - IDX_W - 2;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags [LINES];
  logic [INST_W-1:0] data [LINES];

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] fl_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [TAG_W-1:0] fl_tag;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[31:IDX_W+2];
  assign fl_idx = fill_pc[IDX_W+1:2];
  assign fl_tag = fill_pc[31:IDX_W+2];

  assign hit   = valid[lk_idx] && (tags[lk_idx] == lk_tag);
  assign rdata = data[lk_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (fill) begin
      valid[fl_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: they are only observed behind a set valid bit.
  always_ff @(posedge clk) begin
    if (fill) begin
      tags[fl_idx] <= fl_tag;
      data[fl_idx] <= fill_data;
    end
  end

endmodule
`endif

// File: rtl/if_fetch.sv
// Instruction fetch: assembles 32-bit words from four byte reads and holds the last word.
// Optional direct-mapped cache enabled by defining IF_ICACHE_EN.
//
// state    | meaning
// IF_IDLE  | no fetch in flight; a miss with ce_i starts one
// IF_REQ   | requesting byte fpc+k, collecting bytes 0..3
// IF_DRAIN | flushed with a read outstanding; swallow its byte
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int ICACHE_LINES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       pc_i,
  input  logic              ce_i,
  input  logic              flush_i,
  output logic [INST_W-1:0] inst_o,
  output logic              stallreq_o,
  output logic [31:0]       mem_addr_o,
  output logic              mem_re_o,
  input  logic [BYTE_W-1:0] mem_rdata_i,
  input  logic              mem_rvalid_i
);

  if (ICACHE_LINES < 2 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_lines_chk
    $error("ICACHE_LINES must be a power of two >= 2");
  end

  if_state_e state, state_nxt;

  logic [31:0]       fpc, fpc_nxt;
  logic [1:0]        k, k_nxt;
  logic [INST_W-1:0] asm_q, asm_nxt;
  logic [INST_W-1:0] fill_word;
  logic              commit;

  logic              buf_valid;
  logic [31:0]       buf_pc;
  logic [INST_W-1:0] buf_inst;

  logic              buf_hit;
  logic              hit;
  logic [INST_W-1:0] hit_inst;
  logic              active;

  assign buf_hit = buf_valid && (buf_pc == pc_i);

`ifdef IF_ICACHE_EN
  logic              cache_hit;
  logic [INST_W-1:0] cache_inst;

  if_fetch_icache #(
    .LINES(ICACHE_LINES)
  ) u_icache (
    .clk       (clk),
    .rst       (rst),
    .lookup_pc (pc_i[31:2]),
    .hit       (cache_hit),
    .rdata     (cache_inst),
    .fill      (commit),
    .fill_pc   (fpc[31:2]),
    .fill_data (fill_word)
  );

  assign hit      = buf_hit || cache_hit;
  assign hit_inst = buf_hit ? buf_inst : cache_inst;
`else
  assign hit      = buf_hit;
  assign hit_inst = buf_inst;
`endif

  assign active     = ce_i && !rst;
  assign inst_o     = (active && hit) ? hit_inst : '0;
  assign stallreq_o = active && !hit;

  // Request drops in the cycle its byte returns, so each byte is a fresh request.
  assign mem_re_o   = (state == IF_REQ) && !mem_rvalid_i && !rst;
  assign mem_addr_o = fpc + 32'(k);

  assign fill_word  = insert_byte(asm_q, k, mem_rdata_i);

  always_comb begin
    state_nxt = state;
    fpc_nxt   = fpc;
    k_nxt     = k;
    asm_nxt   = asm_q;
    commit    = 1'b0;
    case (state)
      IF_IDLE: begin
        if (ce_i && !hit && !flush_i) begin
          state_nxt = IF_REQ;
          fpc_nxt   = pc_i;
          k_nxt     = 2'd0;
          asm_nxt   = '0;
        end
      end
      IF_REQ: begin
        if (flush_i) begin
          k_nxt     = 2'd0;
          asm_nxt   = '0;
          state_nxt = mem_rvalid_i ? IF_IDLE : IF_DRAIN;
        end else if (mem_rvalid_i) begin
          if (k == 2'd3) begin
            commit    = 1'b1;
            k_nxt     = 2'd0;
            state_nxt = IF_IDLE;
          end else begin
            asm_nxt = fill_word;
            k_nxt   = k + 2'd1;
          end
        end
      end
      IF_DRAIN: begin
        if (mem_rvalid_i) begin
          state_nxt = IF_IDLE;
        end
      end
      default: state_nxt = IF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IF_IDLE;
      fpc       <= '0;
      k         <= '0;
      asm_q     <= '0;
      buf_valid <= 1'b0;
      buf_pc    <= '0;
      buf_inst  <= '0;
    end else begin
      state <= state_nxt;
      fpc   <= fpc_nxt;
      k     <= k_nxt;
      asm_q <= asm_nxt;
      if (commit) begin
        buf_valid <= 1'b1;
        buf_pc    <= fpc;
        buf_inst  <= fill_word;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: byte-memory model with per-request latency and a
// word-level reference model of the fetch buffer (and cache when IF_ICACHE_EN is defined).
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i;
  logic        flush_i;
  logic [31:0] inst_o;
  logic        stallreq_o;
  logic [31:0] mem_addr_o;
  logic        mem_re_o;
  logic [7:0]  mem_rdata_i;
  logic        mem_rvalid_i;

  if_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .ce_i         (ce_i),
    .flush_i      (flush_i),
    .inst_o       (inst_o),
    .stallreq_o   (stallreq_o),
    .mem_addr_o   (mem_addr_o),
    .mem_re_o     (mem_re_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_rvalid_i (mem_rvalid_i)
  );

  always #5 clk = ~clk;

`ifdef IF_ICACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  mem [256];

  // memory model
  bit          pend;
  bit          loose;
  int          cnt;
  int          delay;
  logic [31:0] paddr;
  logic [31:0] addrq [$];

  // sampled outputs
  logic        o_re;
  logic        o_stall;
  logic [31:0] o_addr;
  logic [31:0] o_inst;

  // reference model
  bit          mbv;
  logic [31:0] mbpc;
  bit          cv   [64];
  logic [23:0] ctag [64];
  logic [31:0] cdat [64];

  function automatic logic [7:0] mb(input logic [31:0] a);
    return mem[a[7:0]];
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] pc);
    return {mb(pc + 32'd3), mb(pc + 32'd2), mb(pc + 32'd1), mb(pc)};
  endfunction

  function automatic bit cache_hit(input logic [31:0] pc);
    logic [5:0] idx;
    idx = pc[7:2];
    return CACHE_ON && cv[idx] && (ctag[idx] == pc[31:8]);
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return (mbv && mbpc == pc) || cache_hit(pc);
  endfunction

  function automatic logic [31:0] model_inst(input logic [31:0] pc);
    logic [5:0] idx;
    idx = pc[7:2];
    if (mbv && mbpc == pc) return ref_word(pc);
    return cdat[idx];
  endfunction

  task automatic model_fill(input logic [31:0] pc);
    logic [5:0] idx;
    idx = pc[7:2];
    mbv = 1'b1;
    mbpc = pc;
    cv[idx] = 1'b1;
    ctag[idx] = pc[31:8];
    cdat[idx] = ref_word(pc);
  endtask

  task automatic model_reset();
    mbv = 1'b0;
    mbpc = '0;
    for (int i = 0; i < 64; i++) cv[i] = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive memory response, sample outputs, advance memory model.
  task automatic cycle();
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 8'h00;
    if (pend && cnt == 0) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = mb(paddr);
    end
    #1;
    o_re = mem_re_o;
    o_stall = stallreq_o;
    o_addr = mem_addr_o;
    o_inst = inst_o;
    if (mem_rvalid_i) begin
      pend = 1'b0;
      loose = 1'b0;
    end else if (pend) begin
      cnt--;
      if (!loose) begin
        chk("req_hold", 32'(o_re), 32'd1);
        chk("addr_hold", o_addr, paddr);
      end
    end else if (o_re) begin
      pend = 1'b1;
      paddr = o_addr;
      cnt = delay - 1;
      addrq.push_back(o_addr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input int d);
    bit miss;
    bit done;
    int st;
    miss = !model_hit(pc);
    delay = d;
    pc_i = pc;
    ce_i = 1'b1;
    addrq.delete();
    st = 0;
    done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      cycle();
      if (o_stall) st++;
      else done = 1'b1;
    end
    chk("fetch_done", 32'(done), 32'd1);
    chk("stall_cycles", st, miss ? 1 + 4 * (d + 1) : 0);
    chk("inst", o_inst, miss ? ref_word(pc) : model_inst(pc));
    chk("req_count", addrq.size(), miss ? 32'd4 : 32'd0);
    for (int i = 0; i < addrq.size(); i++) chk("req_addr", addrq[i], pc + 32'(i));
    if (miss) model_fill(pc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc;
    int          d;
    logic [31:0] exp_q [$];

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;

    rst = 1'b1; ce_i = 1'b0; pc_i = '0; flush_i = 1'b0;
    mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    pend = 1'b0; loose = 1'b0; cnt = 0; delay = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    cycle();
    chk("rst_re", 32'(o_re), 32'd0);
    chk("rst_addr", o_addr, 32'd0);
    chk("rst_stall", 32'(o_stall), 32'd0);
    chk("rst_inst", o_inst, 32'd0);

    // first miss at 0 with 1-cycle memory
    fetch(32'h0, 1);
    chk("word0_const", o_inst, 32'h0010_0513);

    // unchanged pc: no memory traffic
    for (int i = 0; i < 20; i++) begin
      cycle();
      chk("hold_re", 32'(o_re), 32'd0);
      chk("hold_stall", 32'(o_stall), 32'd0);
      chk("hold_inst", o_inst, 32'h0010_0513);
    end

    // slow memory
    fetch(32'h4, 3);

    // ce_i low forces quiet outputs even on a miss
    ce_i = 1'b0; pc_i = 32'h200;
    cycle();
    chk("ce0_stall", 32'(o_stall), 32'd0);
    chk("ce0_inst", o_inst, 32'd0);
    chk("ce0_re", 32'(o_re), 32'd0);

    // flush at k=2 with a byte outstanding, drain while pointing at the buffered pc
    delay = 3; pc_i = 32'h80; ce_i = 1'b1; addrq.delete();
    for (int n = 0; n < 50 && addrq.size() < 3; n++) cycle();
    chk("flush_k2_reached", addrq.size(), 32'd3);
    flush_i = 1'b1; loose = 1'b1;
    cycle();
    flush_i = 1'b0; pc_i = 32'h4;
    for (int n = 0; n < 10 && pend; n++) begin
      cycle();
      chk("drain_re", 32'(o_re), 32'd0);
      chk("drain_stall", 32'(o_stall), 32'd0);
      chk("drain_inst", o_inst, ref_word(32'h4));
    end
    chk("drain_done", 32'(pend), 32'd0);
    fetch(32'h40, 1);

    // flush coinciding with a returning byte restarts the fetch from byte 0
    delay = 2; pc_i = 32'hC0; addrq.delete();
    for (int n = 0; n < 50 && !(addrq.size() == 2 && pend && cnt == 0); n++) cycle();
    chk("flush_rv_reached", addrq.size(), 32'd2);
    flush_i = 1'b1;
    cycle();
    flush_i = 1'b0;
    fetch(32'hC0, 2);

    // pc change mid-fetch: old fetch completes, then new one runs
    delay = 1; pc_i = 32'h10; addrq.delete();
    for (int n = 0; n < 20 && addrq.size() < 1; n++) cycle();
    pc_i = 32'h20;
    o_stall = 1'b1;
    for (int n = 0; n < 100 && o_stall; n++) cycle();
    chk("retarget_done", 32'(o_stall), 32'd0);
    exp_q = '{32'h10, 32'h11, 32'h12, 32'h13, 32'h20, 32'h21, 32'h22, 32'h23};
    chk("retarget_count", addrq.size(), 32'd8);
    for (int i = 0; i < 8 && i < addrq.size(); i++) chk("retarget_addr", addrq[i], exp_q[i]);
    chk("retarget_inst", o_inst, ref_word(32'h20));
    model_fill(32'h10);
    model_fill(32'h20);

    // address wrap with misaligned pc
    fetch(32'hFFFF_FFFE, 1);

    // reset at k=1
    delay = 2; pc_i = 32'hFFFF_FFFC; addrq.delete();
    for (int n = 0; n < 20 && addrq.size() < 2; n++) cycle();
    chk("rst_k1_addr0", addrq.size() > 0 ? addrq[0] : 32'hx, 32'hFFFF_FFFC);
    chk("rst_k1_addr1", addrq.size() > 1 ? addrq[1] : 32'hx, 32'hFFFF_FFFD);
    rst = 1'b1; loose = 1'b1;
    cycle();
    rst = 1'b0; ce_i = 1'b0;
    model_reset();
    for (int n = 0; n < 10; n++) begin
      cycle();
      chk("post_rst_re", 32'(o_re), 32'd0);
    end
    fetch(32'hFFFF_FFFE, 1);

    // aliasing sequence (0x0 and 0x100 share a line when the cache is built in)
    fetch(32'h0, 1);
    fetch(32'h4, 1);
    fetch(32'h0, 1);
    fetch(32'h100, 1);
    fetch(32'h4, 1);
    fetch(32'h0, 1);

    // randomized mix of repeats, aliases and arbitrary pcs
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0: pc = 32'h0;
        1: pc = 32'h4;
        2: pc = 32'h100;
        3: pc = 32'h104;
        4: pc = $urandom & 32'hFFFF_FFFC;
        default: pc = $urandom;
      endcase
      d = $urandom_range(1, 4);
      if ($urandom_range(0, 4) == 0) begin
        ce_i = 1'b0; pc_i = pc;
        cycle();
        chk("rnd_ce0_stall", 32'(o_stall), 32'd0);
        chk("rnd_ce0_inst", o_inst, 32'd0);
      end
      fetch(pc, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage between pc_reg and a byte-wide instruction memory. Feeds if_id with full 32-bit instructions.
- Assembles each 32-bit little-endian instruction from four sequential byte reads.
- Raises stallreq_o to ctrl (new stallreq_from_if source) until the word at pc_i is available.
- Holds the last fetched word so a stalled or unchanged PC costs no memory traffic.

Parameters:
- ICACHE_LINES, 64, number of direct-mapped one-word cache lines; power of two, ≥2; used only with IF_ICACHE_EN.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- pc_i  input  32  fetch address from pc_reg
- ce_i  input  1  fetch enable from pc_reg (rom_ce)
- flush_i  input  1  abort the in-progress fetch (branch redirect)
- inst_o  output  32  instruction for pc_i; valid when ce_i=1 and stallreq_o=0
- stallreq_o  output  1  stall request to ctrl
- mem_addr_o  output  32  byte address to instruction memory
- mem_re_o  output  1  read request; held until mem_rvalid_i
- mem_rdata_i  input  8  read byte
- mem_rvalid_i  input  1  byte valid; earliest one cycle after mem_re_o rises

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; buf_valid=0; buf_pc=0; buf_inst=0; inst_o=0; mem_re_o=0; mem_addr_o=0; stallreq_o=0. Reset mid-fetch drops the request immediately; a late mem_rvalid_i is ignored.
- Hit (combinational): buf_valid && buf_pc==pc_i.
  - inst_o = buf_inst on hit, else 0.
  - stallreq_o = ce_i && !hit.
  - ce_i=0 forces inst_o=0 and stallreq_o=0.
- States: IDLE, REQ, DRAIN.
- IDLE:
  - ce_i && !hit && !flush_i → latch fpc=pc_i, k=0, go to REQ.
  - mem_re_o=1 from the next cycle, with mem_addr_o = fpc+k.
- REQ:
  - mem_re_o=1, mem_addr_o = fpc+k (mod 2^32; 0xFFFFFFFF+1 wraps to 0).
  - On mem_rvalid_i: byte[k] = mem_rdata_i, so inst bits [8k+7:8k].
    - k<3: k++, stay in REQ.
    - k=3: write buf_inst, buf_pc=fpc, buf_valid=1, go to IDLE.
  - mem_re_o drops for one cycle between bytes. Each byte is a new request.
- Miss latency with a 1-cycle memory:
  - stallreq_o high 9 cycles: 4×(request + response) + 1 commit cycle.
  - inst_o is valid in cycle 10.
- PC change during REQ without flush: the fetch completes into the buffer with the old fpc. The next hit check misses and a new fetch starts. No mid-fetch retarget.
- flush_i:
  - IDLE: no effect.
  - REQ with mem_rvalid_i=0: go to DRAIN, drop mem_re_o, discard partial bytes.
  - REQ with mem_rvalid_i=1 in the same cycle: discard that byte, go to IDLE.
  - DRAIN: wait for mem_rvalid_i, discard the byte, go to IDLE. Prevents a stale byte landing in the next fetch.
  - flush_i never clears buf_valid. stallreq_o in DRAIN follows the hit rule.
- Misaligned pc_i (bits [1:0]≠0): fetched as-is, no exception.
- No writes; instruction memory is read-only.

Optional Feature:
- Macro: IF_ICACHE_EN.
- Defined:
  - Adds a direct-mapped cache of ICACHE_LINES words, index pc[log2(ICACHE_LINES)+1:2], tag pc[31:log2+2].
  - Cache hit is the same as a buffer hit: zero-cycle, no memory traffic.
  - Every completed fetch fills the line.
  - rst clears all valid bits. flush_i does not invalidate.
- Undefined: single-entry buffer only; identical port list.

Decomposition:
- Additions to defines.v:
  - `ByteBus 7:0
  - IF state encodings: IF_IDLE, IF_REQ, IF_DRAIN
  - `IcacheIdxBus
- ctrl gains a stallreq_from_if input that stalls all stages. cpu_riscv rewires the rom_* ports through this block.
- One sub-module: if_icache (tag/data/valid arrays, lookup, fill). Instantiated only under IF_ICACHE_EN.

Test Plan:
- Reset then ce_i=1, pc_i=0, memory bytes 13 05 10 00 with 1-cycle response → mem_addr_o 0,1,2,3; stallreq_o high 9 cycles; inst_o=0x00100513.
- pc_i held at 0 after the fetch → stallreq_o=0, inst_o=0x00100513, mem_re_o stays 0 for 20 cycles.
- Memory response delayed 3 cycles per byte at pc_i=4 → mem_re_o and mem_addr_o held stable until each rvalid; stallreq_o high 17 cycles.
- flush_i at k=2 with rvalid pending, then pc_i=0x40 → stale byte consumed in DRAIN; next fetch addresses 0x40..0x43; inst_o equals memory word at 0x40.
- pc_i=0xFFFFFFFC → addresses FFFFFFFC..FFFFFFFF; rst asserted at k=1 → mem_re_o=0 next cycle, buf_valid=0.
- With IF_ICACHE_EN, fetch 0x0, then 0x4, then 0x0 → third access stallreq_o=0, no mem_re_o. 0x0 and 0x100 with ICACHE_LINES=64 alias to one line, so the second access to either misses.
